// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NREQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic logic [NREQ-1:0] onehot(input sel_t s);
    return NREQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// One-bit 4:1 multiplexer; replicated per data bit by the arbiter datapath.
module mux_4_1 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority pick among four requests, starting the search at ptr.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  sel_t            ptr,
  output logic            found,
  output sel_t            winner
);

  sel_t idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + sel_t'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a DW-bit 4:1 mux with valid/ready handshake.
// Define MUX_ARB_HOLD_EN to let a grant keep up to MAX_HOLD consecutive beats.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   data_a,
  input  logic [DW-1:0]   data_b,
  input  logic [DW-1:0]   data_c,
  input  logic [DW-1:0]   data_d,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready
);

  if (MAX_HOLD == 0) begin : g_bad_hold
    $error("mux_rr_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_t      state, state_nxt;
  sel_t            ptr, ptr_nxt;
  sel_t            sel_nxt;
  logic [NREQ-1:0] gnt_nxt;
  sel_t            rot_ptr;
  logic            idle_found, rot_found;
  sel_t            idle_winner, rot_winner;
  logic            xfer;
  logic            advance;

  assign rot_ptr = sel + sel_t'(1);
  assign xfer    = (state == ARB_BUSY) && req[sel] && out_ready;

  // Two arbitration points: fresh start from ptr, and hand-off after the current owner
  rr_pick4 u_pick_idle (.req(req), .ptr(ptr),     .found(idle_found), .winner(idle_winner));
  rr_pick4 u_pick_rot  (.req(req), .ptr(rot_ptr), .found(rot_found),  .winner(rot_winner));

`ifdef MUX_ARB_HOLD_EN
  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
  logic           keep;

  assign keep = xfer && (hold_cnt < HCW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    ack       = '0;
    out_valid = 1'b0;
    advance   = 1'b0;
`ifdef MUX_ARB_HOLD_EN
    hold_cnt_nxt = hold_cnt;
`endif
    unique case (state)
      ARB_IDLE: begin
        gnt_nxt = '0;
        if (idle_found) begin
          state_nxt = ARB_BUSY;
          sel_nxt   = idle_winner;
          gnt_nxt   = onehot(idle_winner);
        end
      end
      ARB_BUSY: begin
        out_valid = req[sel];
        ack[sel]  = xfer;
        advance   = xfer || !req[sel];
`ifdef MUX_ARB_HOLD_EN
        if (keep) begin
          advance      = 1'b0;
          hold_cnt_nxt = hold_cnt + HCW'(1);
        end else if (advance) begin
          hold_cnt_nxt = '0;
        end
`endif
        // Hand-off: rotate past the current owner and re-arbitrate without a bubble
        if (advance) begin
          ptr_nxt = rot_ptr;
          if (rot_found) begin
            sel_nxt = rot_winner;
            gnt_nxt = onehot(rot_winner);
          end else begin
            state_nxt = ARB_IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < DW; i++) begin : g_mux
    mux_4_1 u_mux (
      .sel (sel),
      .d0  (data_a[i]),
      .d1  (data_b[i]),
      .d2  (data_c[i]),
      .d3  (data_d[i]),
      .y   (out_data[i])
    );
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (hold scenario under MUX_ARB_HOLD_EN).
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] data_a, data_b, data_c, data_d;
  logic [3:0] ack, gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int n_run;
  int n_fail;

  mux_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .ack       (ack),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: state updates at posedge, outputs sampled at the following negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    n_run     = 0;
    n_fail    = 0;
    data_a    = 8'hA5;
    data_b    = 8'hB6;
    data_c    = 8'hC7;
    data_d    = 8'hD8;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;

    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sole requester a gets every beat
    req       = 4'b0001;
    out_ready = 1'b1;
    cyc();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_sel", 32'(sel), 32'h0);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      check("t1_ack", 32'(ack), 32'h1);
      cyc();
    end
    check("t1_ack_last", 32'(ack), 32'h1);
    req = 4'b0000;
    cyc();
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_ack", 32'(ack), 32'h0);

`ifndef MUX_ARB_HOLD_EN
    // 2: all requesting, one beat per grant, rotating without bubbles
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_gnt", 32'(gnt), 32'(exp_seq[i]));
      check("t2_ack", 32'(ack), 32'(exp_seq[i]));
    end
`else
    // 6: all requesting, four beats per grant
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t6_ack", 32'(ack), (i < 4) ? 32'h1 : 32'h2);
    end
`endif

    // 3: b granted, consumer stalls for three cycles
    do_reset();
    req = 4'b1110;
    cyc();
    check("t3_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t3_hold_gnt", 32'(gnt), 32'h2);
      check("t3_hold_sel", 32'(sel), 32'h1);
      check("t3_hold_data", 32'(out_data), 32'hB6);
      check("t3_hold_ack", 32'(ack), 32'h0);
      check("t3_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_ack", 32'(ack), 32'h2);
    cyc();
`ifndef MUX_ARB_HOLD_EN
    check("t3_next_gnt", 32'(gnt), 32'h4);
    check("t3_next_data", 32'(out_data), 32'hC7);
`else
    check("t3_next_gnt", 32'(gnt), 32'h2);
    check("t3_next_data", 32'(out_data), 32'hB6);
`endif

    // 4: b withdraws without transferring, c takes over
    do_reset();
    req = 4'b0010;
    cyc();
    check("t4_gnt_b", 32'(gnt), 32'h2);
    req = 4'b0100;
    #1;
    check("t4_no_ack", 32'(ack), 32'h0);
    check("t4_wd_valid", 32'(out_valid), 32'h0);
    cyc();
    check("t4_gnt_c", 32'(gnt), 32'h4);
    check("t4_sel_c", 32'(sel), 32'h2);
    out_ready = 1'b1;
    #1;
    check("t4_ack_c", 32'(ack), 32'h4);

    // 5: asynchronous reset in the middle of a busy cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_ack", 32'(ack), 32'h0);
    check("t5_rst_sel", 32'(sel), 32'h0);
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("t5_gnt_d", 32'(gnt), 32'h8);
    check("t5_sel_d", 32'(sel), 32'h3);
    check("t5_data_d", 32'(out_data), 32'hD8);
    check("t5_ack_d", 32'(ack), 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
